// File: rtl/x_mux_8_arb_pkg.sv
// Shared types and sizes for the eight-source mux arbiter.
// No logic; no latency; no backpressure.
// Imported by the round-robin picker and the arbiter top.
package x_mux_8_arb_pkg;

    localparam int NUM_SRC = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/x_mux_8_arb_pick.sv
// Round-robin picker: first requester strictly after last_ptr, wrapping modulo 8.
// Latency: combinational.
// Backpressure: none; any=0 when no source requests.
module x_rr_pick_8
    import x_mux_8_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the nearest requester is written last.
    // k = NUM_SRC wraps back to last_ptr itself, which has the lowest priority.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = last_ptr + IDX_W'(k);
            if (req[cand]) begin
                winner = cand;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/x_mux_8_arb.sv
// Round-robin arbiter for one 8:1 mux; optional hold timeout via X_MUX_8_ARB_TIMEOUT_EN.
// Latency: grant/idx/valid appear one cycle after the FSM enters GRANT; all outputs registered.
// Backpressure: owner keeps the mux until i_done, request drop or timeout; then one GAP cycle.
module x_mux_8_arb
    import x_mux_8_arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_req_c,
    input  logic i_req_d,
    input  logic i_req_e,
    input  logic i_req_f,
    input  logic i_req_g,
    input  logic i_req_h,
    input  logic i_done,
    output logic o_gnt_a,
    output logic o_gnt_b,
    output logic o_gnt_c,
    output logic o_gnt_d,
    output logic o_gnt_e,
    output logic o_gnt_f,
    output logic o_gnt_g,
    output logic o_gnt_h,
    output logic o_idx_2,
    output logic o_idx_1,
    output logic o_idx_0,
    output logic o_valid
);

    if (HOLD_MAX < 1) begin : g_hold_range
        $error("HOLD_MAX must be at least 1");
    end

    logic [NUM_SRC-1:0] req_vec;
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, last_ptr_q, pick_idx, idx_q;
    logic               pick_any, rel, timeout;
    logic [NUM_SRC-1:0] gnt_d, gnt_q;
    logic               valid_d, valid_q;

    assign req_vec = {i_req_h, i_req_g, i_req_f, i_req_e,
                      i_req_d, i_req_c, i_req_b, i_req_a};

    x_rr_pick_8 u_pick (
        .req      (req_vec),
        .last_ptr (last_ptr_q),
        .winner   (pick_idx),
        .any      (pick_any)
    );

`ifdef X_MUX_8_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    logic [HOLD_W-1:0] hold_q;

    // Cleared while idle so every GRANT tenure starts counting from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            hold_q <= '0;
        else if (state_q == IDLE)
            hold_q <= '0;
        else if (state_q == GRANT)
            hold_q <= hold_q + HOLD_W'(1);
    end

    assign timeout = (hold_q == HOLD_W'(HOLD_MAX - 1));
`else
    assign timeout = 1'b0;
`endif

    assign rel = i_done | ~req_vec[owner_q] | timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_ptr_q <= IDX_W'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_any)
                owner_q <= pick_idx;
            if (state_q == GRANT && rel)
                last_ptr_q <= owner_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = GRANT;
            GRANT:   if (rel)      state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d   = '0;
        valid_d = (state_q == GRANT);
        if (state_q == GRANT)
            gnt_d[owner_q] = 1'b1;
    end

    // idx follows the owner register, so it holds through GAP and IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            idx_q   <= owner_q;
            valid_q <= valid_d;
        end
    end

    assign {o_gnt_h, o_gnt_g, o_gnt_f, o_gnt_e,
            o_gnt_d, o_gnt_c, o_gnt_b, o_gnt_a} = gnt_q;
    assign {o_idx_2, o_idx_1, o_idx_0}         = idx_q;
    assign o_valid                             = valid_q;

endmodule

// File: tb/tb_x_mux_8_arb.sv
// Bench for x_mux_8_arb: behavioural owner/cool-down model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_x_mux_8_arb;

    localparam int HOLD = 4;
`ifdef X_MUX_8_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    x_mux_8_arb #(.HOLD_MAX(HOLD)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req_a (req[0]), .i_req_b (req[1]), .i_req_c (req[2]), .i_req_d (req[3]),
        .i_req_e (req[4]), .i_req_f (req[5]), .i_req_g (req[6]), .i_req_h (req[7]),
        .i_done  (done),
        .o_gnt_a (gnt[0]), .o_gnt_b (gnt[1]), .o_gnt_c (gnt[2]), .o_gnt_d (gnt[3]),
        .o_gnt_e (gnt[4]), .o_gnt_f (gnt[5]), .o_gnt_g (gnt[6]), .o_gnt_h (gnt[7]),
        .o_idx_2 (idx[2]), .o_idx_1 (idx[1]), .o_idx_0 (idx[0]),
        .o_valid (valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the mux, how long, and how many dead cycles remain.
    // Outputs visible after an edge reflect the ownership held before that edge.
    int   m_own  = -1;
    int   m_held = 0;
    int   m_cool = 0;
    int   m_last = 7;
    int   m_idx  = 0;
    int   m_idx_o = 0;
    logic m_valid_o = 1'b0;
    bit   m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_own = -1; m_held = 0; m_cool = 0; m_last = 7; m_idx = 0;
            m_idx_o = 0; m_valid_o = 1'b0; m_live = 1'b1;
        end else if (m_live) begin
            bit found;
            m_valid_o = (m_own >= 0);
            m_idx_o   = m_idx;
            found     = 1'b0;
            if (m_own >= 0) begin
                m_held++;
                if (done || !req[m_own] || (TO_EN && m_held == HOLD)) begin
                    m_last = m_own;
                    m_own  = -1;
                    m_cool = 1;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else begin
                for (int k = 1; k <= 8; k++) begin
                    if (!found && req[(m_last + k) % 8]) begin
                        found  = 1'b1;
                        m_own  = (m_last + k) % 8;
                        m_idx  = m_own;
                        m_held = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            logic [7:0] exp_gnt;
            exp_gnt = m_valid_o ? (8'h01 << m_idx_o) : 8'h00;
            check("model_valid", 32'(valid), 32'(m_valid_o));
            check("model_idx", 32'(idx), 32'(m_idx_o));
            check("model_gnt", 32'(gnt), 32'(exp_gnt));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 8'h00; done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string name, input int who, input int bound);
        int  n;
        bit  got;
        n = 0; got = 1'b0;
        while (!got && n < bound) begin
            @(negedge clk);
            n++;
            if (valid === 1'b1 && idx == who[2:0]) got = 1'b1;
        end
        check(name, 32'(got), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    initial begin
        int own_seq[$];
        int gaps[$];
        int run_own[$];
        int run_len[$];
        int gapcnt, len, cur, firstv;
        bit prev, seen;

        rst = 1'b1; req = 8'h00; done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_idx", 32'(idx), 32'd0);

        // c alone: grant visible after the second edge
        req = 8'h04;
        @(negedge clk);
        check("c_lat_valid_early", 32'(valid), 32'd0);
        @(negedge clk);
        check("c_gnt", 32'(gnt), 32'h04);
        check("c_idx", 32'(idx), 32'd2);
        check("c_valid", 32'(valid), 32'd1);
        req = 8'h00;
        repeat (4) @(negedge clk);

        // a, d, h with done pulsed each tenure
        do_reset();
        req = 8'h89; gapcnt = 0; prev = 1'b0;
        for (int c = 0; c < 60 && own_seq.size() < 4; c++) begin
            @(negedge clk);
            if (valid === 1'b1 && !prev) begin
                own_seq.push_back(int'(idx));
                if (own_seq.size() > 1) gaps.push_back(gapcnt);
            end
            if (valid === 1'b1) gapcnt = 0; else gapcnt++;
            prev = (valid === 1'b1);
            done = prev;
        end
        done = 1'b0; req = 8'h00;
        check("rr_count", 32'(own_seq.size()), 32'd4);
        for (int i = 0; i < own_seq.size(); i++)
            check("rr_owner", 32'(own_seq[i]), (i == 1) ? 32'd3 : (i == 2) ? 32'd7 : 32'd0);
        for (int i = 0; i < gaps.size(); i++)
            check("rr_gap", 32'(gaps[i]), 32'd2);
        repeat (3) @(negedge clk);

        // e drops request together with done, then re-requests: one GAP only
        req = 8'h10;
        wait_grant("e_grant", 4, 20);
        req = 8'h00; done = 1'b1;
        @(negedge clk);
        check("e_rel_valid_hold", 32'(valid), 32'd1);
        req = 8'h10; done = 1'b0;
        @(negedge clk);
        check("e_gap_valid", 32'(valid), 32'd0);
        @(negedge clk);
        check("e_idle_valid", 32'(valid), 32'd0);
        @(negedge clk);
        check("e_regrant_valid", 32'(valid), 32'd1);
        check("e_regrant_idx", 32'(idx), 32'd4);
        req = 8'h00;
        repeat (3) @(negedge clk);

        // b and f held, never done
        do_reset();
        req = 8'h22;
`ifdef X_MUX_8_ARB_TIMEOUT_EN
        len = 0; cur = 0;
        for (int c = 0; c < 80 && run_len.size() < 3; c++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (len == 0) cur = int'(idx);
                len++;
            end else if (len > 0) begin
                run_own.push_back(cur);
                run_len.push_back(len);
                len = 0;
            end
        end
        check("to_runs", 32'(run_len.size()), 32'd3);
        for (int i = 0; i < run_len.size(); i++) begin
            check("to_owner", 32'(run_own[i]), (i % 2 == 0) ? 32'd1 : 32'd5);
            check("to_len", 32'(run_len[i]), 32'(HOLD));
        end
`else
        repeat (102) @(negedge clk);
        check("hold_gnt_b", 32'(gnt), 32'h02);
        check("hold_valid", 32'(valid), 32'd1);
`endif
        req = 8'h00;
        repeat (3) @(negedge clk);

        // reset in the middle of g's tenure, then a beats g
        req = 8'h40;
        wait_grant("g_grant", 6, 20);
        rst = 1'b1; req = 8'h41;
        @(negedge clk);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_idx", 32'(idx), 32'd0);
        rst = 1'b0;
        seen = 1'b0; firstv = -1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (valid === 1'b1) begin seen = 1'b1; firstv = int'(idx); end
        end
        check("midrst_first_owner", 32'(firstv), 32'd0);
        req = 8'h00;

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int b = 0; b < 8; b++)
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            done = ($urandom_range(3) == 0);
            rst  = ($urandom_range(149) == 0);
        end
        rst = 1'b0; done = 1'b0; req = 8'h00;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/x_mux_8_arb.md
# x_mux_8_arb

Round-robin arbiter that shares one `x_mux_8_to_1` datapath between eight single-bit requesters a..h. It drives the mux select bits, `o_idx_2..o_idx_0`, and a one-hot grant back to the sources. It also raises a valid flag while the mux output belongs to a granted owner. It sits directly upstream of the mux select pins; the mux data inputs are wired straight from the sources.

## Interface
Parameters:
- `HOLD_MAX`, default 15: maximum cycles one owner may hold the grant before forced release. Legal range ≥1. Only used with the timeout macro.

Ports:
- `i_clk`, in, 1: clock, rising edge.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_req_a` … `i_req_h`, in, 1 each: request from source a..h.
- `i_done`, in, 1: current owner releases the mux.
- `o_gnt_a` … `o_gnt_h`, out, 1 each: one-hot grant to source a..h.
- `o_idx_2`, `o_idx_1`, `o_idx_0`, out, 1 each: mux select. a=0 … h=7; `o_idx_2` is the MSB.
- `o_valid`, out, 1: mux output is owned and valid this cycle.

## Operation
- Encoding: source index 0..7 = a..h.
- State machine, three states: IDLE, GRANT, GAP.
- IDLE:
  - If any `i_req_*` is high, pick the first requesting index strictly after `last_ptr`, modulo 8, wrapping.
  - Register the winner as owner; go to GRANT.
  - If no request is high, stay in IDLE.
- GRANT:
  - `o_gnt_<owner>`=1, `o_idx`=owner, `o_valid`=1.
  - Release to GAP when any of these holds:
    - `i_done`=1;
    - `i_req_<owner>`=0;
    - the timeout fires (macro only).
  - On release, `last_ptr` ← owner.
- GAP: one turnaround cycle. All grants 0, `o_valid`=0, `o_idx` holds the last owner. Next state is IDLE, unconditionally.
- Requests from non-owners during GRANT or GAP are ignored. `i_done` outside GRANT is ignored.
- Simultaneous release causes (`i_done` + req drop + timeout) produce one release, one GAP.
- A single persistent requester is re-granted after each GAP; round-robin wraps to itself.
- `o_idx` is a registered copy of owner, never a combinational function of the requests.

## Timing
- Reset, on any edge with `i_rst`=1, including mid-GRANT:
  - state=IDLE, `last_ptr`=7 (a has first priority), owner=0, hold counter=0;
  - all `o_gnt_*`=0, `o_idx_*`=0, `o_valid`=0 from the next cycle.
- Grant latency:
  - Request sampled high in IDLE at edge N → grant, `o_idx` and `o_valid` high after edge N+1.
  - Worst case from a release back to the next grant: GAP (1) + IDLE (1) = 2 dead cycles.
- Release latency: release cause seen at edge N → grant and valid drop after edge N+1.
- All outputs are registered, with no combinational input-to-output path.

## Configuration
- Macro `X_MUX_8_ARB_TIMEOUT_EN`.
- Defined:
  - Hold counter, width `$clog2(HOLD_MAX+1)`, cleared on entry to GRANT and incremented each GRANT cycle.
  - Forced release when counter == HOLD_MAX−1, so the owner holds exactly HOLD_MAX cycles.
- Undefined: no counter; grant is held until `i_done` or a request drop. `HOLD_MAX` is ignored.

## Structure
- Package `x_mux_8_arb_pkg`:
  - state enum (IDLE, GRANT, GAP);
  - `NUM_SRC`=8, `IDX_W`=3.
- Sub-module `x_rr_pick_8`, combinational: inputs are the 8-bit request vector and 3-bit `last_ptr`; outputs are the 3-bit winner and `any`.
- The top holds the FSM, the owner/ptr registers, the optional counter and the output registers. It packs the individual request bits into a vector internally.

## Test plan
- Reset then `i_req_c`=1 held → after 2 edges `o_gnt_c`=1, idx=010, `o_valid`=1.
- Requests a, d, h held, `i_done` pulsed each grant → owners cycle a, d, h, a. There are 2 non-valid cycles between grants.
- Owner e drops `i_req_e` together with `i_done`=1 → exactly one GAP cycle, then IDLE; `o_valid`=0 throughout.
- Macro on, `HOLD_MAX`=4, `i_req_b`, `i_req_f` held, no `i_done` → b valid 4 cycles, then f valid 4 cycles, then b, alternating.
- Macro off, same stimulus → b holds indefinitely; after 100 cycles still `o_gnt_b`=1.
- `i_rst`=1 mid-GRANT of g → the next cycle has all outputs 0 and state IDLE. With a and g both requesting after reset, a is granted first.
